if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction word used for bubbles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port PCWrite  input  1  hazard unit: PC may advance.
REQ-006 SHALL have port IF_ID_Write  input  1  hazard unit: IF/ID register may load.
REQ-007 SHALL have port IF_Flush  input  1  hazard unit: taken branch, squash fetch.
REQ-008 SHALL have port branch_target  input  32  redirect PC, sampled when IF_Flush=1.
REQ-009 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-010 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port imem_addr  output  32  fetch address, equal to PC.
REQ-012 SHALL have port imem_rsp_valid  input  1  response data valid.
REQ-013 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-014 SHALL have ports IF_ID_PC (output, 32), IF_ID_Instr (output, 32), IF_ID_Valid (output, 1): IF/ID register contents.

Function
REQ-015 SHALL keep at most one outstanding imem request; handshake = imem_req_valid & imem_req_ready.
REQ-016 SHALL implement FSM states REQ, WAIT, HOLD, DISCARD; reset state REQ.
REQ-017 REQ: imem_req_valid=1, imem_addr=PC; handshake -> WAIT; no handshake -> stay.
REQ-018 WAIT: imem_rsp_valid with PCWrite=1 and IF_ID_Write=1 -> load IF/ID {PC, rdata, 1}, PC<=PC+4, -> REQ.
REQ-019 WAIT: imem_rsp_valid with PCWrite=0 or IF_ID_Write=0 -> capture {PC, rdata} in hold buffer, -> HOLD.
REQ-020 HOLD: PCWrite=1 and IF_ID_Write=1 -> load IF/ID from hold buffer, PC<=PC+4, -> REQ; else stay, buffer unchanged.
REQ-021 DISCARD: drop next response, no IF/ID load; imem_rsp_valid -> REQ.
REQ-022 IF_Flush SHALL override stall inputs: PC<=branch_target with bits[1:0] forced to 0, hold buffer discarded, IF/ID <= {PC unchanged, NOP_INSTR, 0}.
REQ-023 IF_Flush next state: REQ->REQ without handshake; REQ->DISCARD with handshake; WAIT->DISCARD without response; WAIT->REQ with same-cycle response (response dropped); HOLD->REQ; DISCARD->DISCARD (->REQ if response same cycle).
REQ-024 IF_ID_Write=1 with no instruction delivered that cycle SHALL load bubble {IF_ID_PC unchanged, NOP_INSTR, 0}.
REQ-025 IF_ID_Write=0 and IF_Flush=0 SHALL hold all IF/ID outputs.
REQ-026 PC SHALL change only per REQ-018/020/022; PC+4 wraps modulo 2^32.
REQ-027 Latency with memory always ready, 1-cycle response, no stalls: request cycle N, IF_ID_Valid=1 at N+2; one instruction per 2 cycles.
REQ-028 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0 unless IF_Flush.

Reset
REQ-029 On rst=1 at a clock edge: PC=RESET_PC, state REQ, hold buffer empty, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0.
REQ-030 imem_req_valid SHALL be 0 in any cycle rst=1.
REQ-031 Reset mid-operation SHALL abandon the outstanding request; a response arriving within 1 cycle after reset release SHALL be ignored (treated as DISCARD).

Structure
REQ-032 Shared package pipeline_pkg SHALL hold XLEN=32, NOP constant, and the fetch FSM state enum.
REQ-033 IF/ID register with stall/flush/bubble SHALL be sub-module if_id_reg; FSM, PC and hold buffer stay in if_id_stage.

Verification
REQ-034 Reset, ready=1, 1-cycle memory returning addr-derived data -> imem_addr 0,4,8 on alternate cycles; IF_ID_PC 0,4,8 with Valid=1.
REQ-035 Load-use stall (PCWrite=0, IF_ID_Write=0 for 2 cycles) while response returns at PC=8 -> HOLD, IF/ID outputs frozen, instruction 8 delivered once after release, no duplicate/loss.
REQ-036 IF_Flush with branch_target=32'h40 while WAIT -> stale response dropped, IF_ID_Valid=0, Instr=32'h13, next imem_addr=32'h40.
REQ-037 IF_Flush and PCWrite=0 same cycle -> flush wins, PC=branch_target; branch_target=32'h43 -> imem_addr=32'h40.
REQ-038 PC=32'hFFFF_FFFC fetch -> next imem_addr=32'h0000_0000.
REQ-039 imem_req_ready=0 for 3 cycles -> imem_addr stable, no IF/ID load; rst asserted mid-WAIT -> PC=RESET_PC, Valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, the canonical NOP word, and
// the fetch FSM state encoding used by the IF/ID stage.
package pipeline_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- the word inserted for bubbles and squashed fetches
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // Fetch FSM states:
    //   FETCH_REQ     - presenting a request at PC
    //   FETCH_WAIT    - request accepted, waiting for the response
    //   FETCH_HOLD    - response captured, waiting for the stall to clear
    //   FETCH_DISCARD - a squashed request is still in flight; drop its response
    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_HOLD    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetchState_t;

    // Branch targets are word aligned by clearing the two low bits.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory port of the fetch stage.
//
// Request channel: a request transfers on a rising edge where
// imem_req_valid && imem_req_ready. While imem_req_valid is high and
// imem_req_ready is low the requester keeps imem_addr stable (a taken-branch
// flush is the only thing allowed to move it). Response channel: no ready;
// the memory asserts imem_rsp_valid for exactly one cycle with imem_rdata,
// and at most one request is ever outstanding.
interface if_id_stage_if;
    import pipeline_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;

    // Fetch stage side
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    // Instruction memory side
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush (squash to NOP), load of a
// fetched instruction, bubble when the stage may write but nothing arrived,
// otherwise hold. Flush and bubble keep the previous PC field.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            write,
    input  logic            load,
    input  logic [XLEN-1:0] loadPc,
    input  logic [XLEN-1:0] loadInstr,
    output logic [XLEN-1:0] pcOut,
    output logic [XLEN-1:0] instrOut,
    output logic            validOut
);

    // Register update with flush > load > bubble > hold priority
    always_ff @(posedge clk) begin
        if (rst) begin
            pcOut    <= '0;
            instrOut <= NOP_INSTR;
            validOut <= 1'b0;
        end else if (flush) begin
            instrOut <= NOP_INSTR;
            validOut <= 1'b0;
        end else if (load) begin
            pcOut    <= loadPc;
            instrOut <= loadInstr;
            validOut <= 1'b1;
        end else if (write) begin
            instrOut <= NOP_INSTR;
            validOut <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: owns the PC, a single-outstanding fetch FSM talking
// to instruction memory, and a one-entry hold buffer that parks a returned
// instruction while the hazard unit stalls. Feeds the IF/ID register.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            IF_Flush,
    input  logic [XLEN-1:0] branch_target,
    if_id_stage_if.master   imem,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_Instr,
    output logic            IF_ID_Valid,
    output fetchState_t     fetchState
);

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] holdPc;
    logic [XLEN-1:0] holdInstr;
    logic            reqValid;
    logic            handshake;
    logic            advance;
    logic            deliver;
    logic            capture;
    logic [XLEN-1:0] deliverPc;
    logic [XLEN-1:0] deliverInstr;

    // Requests only go out from FETCH_REQ, and never while reset is held so
    // nothing is issued that the reset would immediately abandon.
    assign reqValid            = (state == FETCH_REQ) && !rst;
    assign imem.imem_req_valid = reqValid;
    assign imem.imem_addr      = pc;
    assign handshake           = reqValid && imem.imem_req_ready;
    assign advance             = PCWrite && IF_ID_Write;
    assign fetchState          = state;

    // Next state, PC update and IF/ID load decision; flush overrides stalls
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        deliver      = 1'b0;
        capture      = 1'b0;
        deliverPc    = pc;
        deliverInstr = imem.imem_rdata;

        case (state)
            FETCH_REQ: begin
                // A request accepted in the flush cycle fetches the wrong path
                if (handshake) begin
                    stateNext = IF_Flush ? FETCH_DISCARD : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (IF_Flush) begin
                        stateNext = FETCH_REQ;
                    end else if (advance) begin
                        deliver   = 1'b1;
                        stateNext = FETCH_REQ;
                    end else begin
                        capture   = 1'b1;
                        stateNext = FETCH_HOLD;
                    end
                end else if (IF_Flush) begin
                    stateNext = FETCH_DISCARD;
                end
            end
            FETCH_HOLD: begin
                if (IF_Flush) begin
                    stateNext = FETCH_REQ;
                end else if (advance) begin
                    deliver      = 1'b1;
                    deliverPc    = holdPc;
                    deliverInstr = holdInstr;
                    stateNext    = FETCH_REQ;
                end
            end
            FETCH_DISCARD: begin
                if (imem.imem_rsp_valid) begin
                    stateNext = FETCH_REQ;
                end
            end
            default: begin
                stateNext = FETCH_REQ;
            end
        endcase

        if (IF_Flush) begin
            pcNext = alignPc(branch_target);
        end else if (deliver) begin
            pcNext = deliverPc + XLEN'(4);
        end
    end

    // FSM state and PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    // Hold buffer: parks a response that arrived while the pipeline stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            holdPc    <= '0;
            holdInstr <= '0;
        end else if (capture) begin
            holdPc    <= pc;
            holdInstr <= imem.imem_rdata;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) ifIdReg (
        .clk       (clk),
        .rst       (rst),
        .flush     (IF_Flush),
        .write     (IF_ID_Write),
        .load      (deliver),
        .loadPc    (deliverPc),
        .loadInstr (deliverInstr),
        .pcOut     (IF_ID_PC),
        .instrOut  (IF_ID_Instr),
        .validOut  (IF_ID_Valid)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a directed vector table, two hand-written corner
// sequences, then randomized traffic against a transaction-level model that
// tracks outstanding requests and parked instructions as queues.
module tb_if_id_stage;
    import pipeline_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_Flush;
    logic [31:0] branch_target;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    fetchState_t dbgState;

    if_id_stage_if mif();

    if_id_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .IF_Flush      (IF_Flush),
        .branch_target (branch_target),
        .imem          (mif),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .fetchState    (dbgState)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic        memBusy   = 1'b0;
    logic [31:0] memAddr   = '0;
    int          memDelay  = 0;
    int          memLatMin = 1;
    int          memLatMax = 1;
    logic        injectRsp = 1'b0;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic drive_mem();
        if (injectRsp) begin
            mif.imem_rsp_valid = 1'b1;
            mif.imem_rdata     = 32'hDEAD_BEEF;
            injectRsp          = 1'b0;
        end else if (memBusy && memDelay == 0) begin
            mif.imem_rsp_valid = 1'b1;
            mif.imem_rdata     = memData(memAddr);
        end else begin
            mif.imem_rsp_valid = 1'b0;
            mif.imem_rdata     = $urandom;
        end
    endtask

    task automatic mem_update();
        if (rst) begin
            memBusy = 1'b0;
        end else begin
            if (memBusy) begin
                if (memDelay == 0) memBusy = 1'b0;
                else memDelay--;
            end
            if (mif.imem_req_valid && mif.imem_req_ready) begin
                memBusy  = 1'b1;
                memAddr  = mif.imem_addr;
                memDelay = int'($urandom_range(memLatMax, memLatMin)) - 1;
            end
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] addr; logic stale; } outReq_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } fetched_t;

    outReq_t     outQ[$];   // requests accepted by memory, not yet answered
    fetched_t    parkQ[$];  // instructions returned during a stall
    logic [31:0] expQ[$];   // PCs the model has delivered, in order
    logic [31:0] mPc      = RST_PC;
    logic [31:0] mIfPc    = '0;
    logic [31:0] mIfInstr = NOP_W;
    logic        mIfValid = 1'b0;
    logic        prevIdw  = 1'b0;

    function automatic logic model_req_valid();
        return !rst && outQ.size() == 0 && parkQ.size() == 0;
    endfunction

    task automatic model_step();
        logic        hs;
        logic        go;
        logic        haveDel;
        fetched_t    del;
        outReq_t     o;
        logic [31:0] issueAddr;
        if (rst) begin
            mPc = RST_PC;
            outQ.delete();
            parkQ.delete();
            mIfPc    = '0;
            mIfInstr = NOP_W;
            mIfValid = 1'b0;
            return;
        end
        hs        = model_req_valid() && mif.imem_req_ready;
        issueAddr = mPc;
        go        = PCWrite && IF_ID_Write;
        haveDel   = 1'b0;
        del       = '0;
        if (mif.imem_rsp_valid && outQ.size() > 0) begin
            o = outQ.pop_front();
            if (!o.stale && !IF_Flush) begin
                if (go) begin
                    haveDel = 1'b1;
                    del     = '{pc: o.addr, instr: mif.imem_rdata};
                end else begin
                    parkQ.push_back('{pc: o.addr, instr: mif.imem_rdata});
                end
            end
        end else if (parkQ.size() > 0 && go && !IF_Flush) begin
            haveDel = 1'b1;
            del     = parkQ.pop_front();
        end
        if (IF_Flush) begin
            mPc = branch_target & ~32'd3;
            parkQ.delete();
            foreach (outQ[i]) outQ[i].stale = 1'b1;
            mIfInstr = NOP_W;
            mIfValid = 1'b0;
        end else if (haveDel) begin
            mPc      = del.pc + 32'd4;
            mIfPc    = del.pc;
            mIfInstr = del.instr;
            mIfValid = 1'b1;
            expQ.push_back(del.pc);
        end else if (IF_ID_Write) begin
            mIfInstr = NOP_W;
            mIfValid = 1'b0;
        end
        if (hs) outQ.push_back('{addr: issueAddr, stale: IF_Flush});
    endtask

    task automatic check_model();
        chk("req_valid", 32'(mif.imem_req_valid), 32'(model_req_valid()));
        chk("imem_addr", mif.imem_addr, mPc);
        chk("if_id_pc", IF_ID_PC, mIfPc);
        chk("if_id_instr", IF_ID_Instr, mIfInstr);
        chk("if_id_valid", 32'(IF_ID_Valid), 32'(mIfValid));
        if (IF_ID_Valid === 1'b1 && prevIdw) begin
            if (expQ.size() == 0) chk("delivery_count", 32'd1, 32'd0);
            else chk("delivery_order", IF_ID_PC, expQ.pop_front());
        end
    endtask

    // One clock: inputs already applied; sample at negedge, advance model.
    task automatic cycle(input bit doCheck, input bit doStep);
        drive_mem();
        @(negedge clk);
        if (doCheck) check_model();
        if (doStep) model_step();
        mem_update();
        prevIdw = IF_ID_Write;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        pcw;
        logic        idw;
        logic        flush;
        logic [31:0] bt;
        logic        rdy;
        logic        expReqValid;
        logic [31:0] expAddr;
        logic [31:0] expPc;
        logic        expValid;
    } vec_t;

    vec_t vecQ[$];

    task automatic add_vec(input logic r, input logic pw, input logic iw, input logic fl,
                           input logic [31:0] bt, input logic rdy,
                           input logic erv, input logic [31:0] ea, input logic [31:0] ep,
                           input logic ev);
        vec_t v;
        v.rst = r; v.pcw = pw; v.idw = iw; v.flush = fl; v.bt = bt; v.rdy = rdy;
        v.expReqValid = erv; v.expAddr = ea; v.expPc = ep; v.expValid = ev;
        vecQ.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //       rst pw iw fl bt            rdy | rv addr          ifPc          v
        add_vec(1, 1, 1, 0, 32'h0,         1,   0, 32'h0,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h0,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'h0,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h4,        32'h0,        1);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'h4,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h8,        32'h4,        1);
        add_vec(0, 0, 0, 0, 32'h0,         1,   0, 32'h8,        32'h4,        0);
        add_vec(0, 0, 0, 0, 32'h0,         1,   0, 32'h8,        32'h4,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'h8,        32'h4,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'hC,        32'h8,        1);
        add_vec(0, 1, 1, 1, 32'h40,        1,   0, 32'hC,        32'h8,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h40,       32'h8,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'h40,       32'h8,        0);
        add_vec(0, 0, 1, 1, 32'h43,        0,   1, 32'h44,       32'h40,       1);
        add_vec(0, 1, 1, 1, 32'hFFFF_FFFC, 0,   1, 32'h40,       32'h40,       0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 32'h40,      0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'hFFFF_FFFC, 32'h40,      0);
        add_vec(0, 1, 1, 0, 32'h0,         0,   1, 32'h0,        32'hFFFF_FFFC, 1);
        add_vec(0, 1, 1, 0, 32'h0,         0,   1, 32'h0,        32'hFFFF_FFFC, 0);
        add_vec(0, 1, 1, 0, 32'h0,         0,   1, 32'h0,        32'hFFFF_FFFC, 0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h0,        32'hFFFF_FFFC, 0);
        add_vec(1, 1, 1, 0, 32'h0,         1,   0, 32'h0,        32'hFFFF_FFFC, 0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h0,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   0, 32'h0,        32'h0,        0);
        add_vec(0, 1, 1, 0, 32'h0,         1,   1, 32'h4,        32'h0,        1);

        // Preamble reset
        rst = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
        branch_target = '0;
        mif.imem_req_ready = 1'b1;
        drive_mem();
        @(posedge clk);
        #1;
        chk("reset_state", 32'(dbgState), 32'(FETCH_REQ));

        foreach (vecQ[i]) begin
            rst                = vecQ[i].rst;
            PCWrite            = vecQ[i].pcw;
            IF_ID_Write        = vecQ[i].idw;
            IF_Flush           = vecQ[i].flush;
            branch_target      = vecQ[i].bt;
            mif.imem_req_ready = vecQ[i].rdy;
            drive_mem();
            @(negedge clk);
            chk($sformatf("row%0d_req_valid", i), 32'(mif.imem_req_valid), 32'(vecQ[i].expReqValid));
            chk($sformatf("row%0d_addr", i), mif.imem_addr, vecQ[i].expAddr);
            chk($sformatf("row%0d_if_pc", i), IF_ID_PC, vecQ[i].expPc);
            chk($sformatf("row%0d_if_valid", i), 32'(IF_ID_Valid), 32'(vecQ[i].expValid));
            chk($sformatf("row%0d_if_instr", i), IF_ID_Instr,
                vecQ[i].expValid ? memData(vecQ[i].expPc) : NOP_W);
            mem_update();
            prevIdw = IF_ID_Write;
            @(posedge clk);
            #1;
        end

        // Resynchronise the model with the DUT through a reset cycle
        rst = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
        branch_target = '0; mif.imem_req_ready = 1'b1;
        cycle(0, 1);
        expQ.delete();

        // Flush while waiting with the response still two cycles away
        rst = 1'b0; memLatMin = 3; memLatMax = 3;
        cycle(1, 1);
        IF_Flush = 1'b1; branch_target = 32'h100;
        cycle(1, 1);
        IF_Flush = 1'b0;
        cycle(1, 1);
        cycle(1, 1);
        chk("discard_addr", mif.imem_addr, 32'h100);
        chk("discard_req_valid", 32'(mif.imem_req_valid), 32'd1);
        chk("discard_if_valid", 32'(IF_ID_Valid), 32'd0);
        chk("discard_if_instr", IF_ID_Instr, NOP_W);

        // Reset mid-WAIT, then a stale response right after release
        memLatMin = 2; memLatMax = 2;
        cycle(1, 1);
        rst = 1'b1;
        cycle(1, 1);
        rst = 1'b0; injectRsp = 1'b1;
        cycle(1, 1);
        chk("post_rst_if_valid", 32'(IF_ID_Valid), 32'd0);
        chk("post_rst_if_instr", IF_ID_Instr, NOP_W);
        chk("post_rst_if_pc", IF_ID_PC, 32'h0);
        chk("post_rst_state", 32'(dbgState), 32'(FETCH_WAIT));
        cycle(1, 1);
        cycle(1, 1);
        chk("post_rst_deliver_valid", 32'(IF_ID_Valid), 32'd1);
        chk("post_rst_deliver_pc", IF_ID_PC, RST_PC);
        chk("post_rst_deliver_instr", IF_ID_Instr, memData(RST_PC));

        // Randomized traffic
        memLatMin = 1; memLatMax = 3;
        for (int n = 0; n < 3000; n++) begin
            rst                = ($urandom_range(199, 0) == 0);
            PCWrite            = ($urandom_range(3, 0) != 0);
            IF_ID_Write        = ($urandom_range(3, 0) != 0);
            IF_Flush           = ($urandom_range(15, 0) == 0);
            branch_target      = ($urandom_range(7, 0) == 0) ?
                                 (32'hFFFF_FFF8 | 32'($urandom_range(7, 0))) : $urandom;
            mif.imem_req_ready = ($urandom_range(3, 0) != 0);
            cycle(1, 1);
        end
        rst = 1'b0; IF_Flush = 1'b0; PCWrite = 1'b0; IF_ID_Write = 1'b0;
        cycle(1, 0);
        chk("exp_q_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
